alu_seq: RTL
============

# alu_seq

Parametrised successor to the combinational datapath ALU. It adds shifts, SLT, NOR and signed overflow on the single-cycle path, plus an iterative multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake. It sits in the EX stage; the pipeline control stalls on `busy`.

## Interface
- `WIDTH`, 32: datapath width; must be even and at least 8.
- `SHAMT_W`, 5: shift-amount width; must equal `$clog2(WIDTH)`.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `input1`, `input2` in WIDTH: operands (rs, rt).
- `aluControl` in 4: operation select.
- `shamt` in SHAMT_W: shift amount for SLL/SRL/SRA.
- `start` in 1: one-cycle request for a MULT/MULTU/DIV/DIVU code.
- `aluResult` out WIDTH: combinational result.
- `zero` out 1: high when `aluResult` is all zeros.
- `overflow` out 1: signed overflow of ADD/SUB; 0 for all other ops.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse; HI/LO have just been updated.
- `hi`, `lo` out WIDTH: registered HI/LO.

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0 or 1), 1100 NOR, 0011 SLL, 0100 SRL, 0101 SRA, 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1101 MFHI, 1110 MFLO. Any other code gives `aluResult` = 0.
- Shifts operate on `input2` by `shamt`. ADD/SUB wrap modulo 2^WIDTH.
- For MULT/MULTU/DIV/DIVU codes, `aluResult` = 0. MFHI/MFLO return the current registered `hi`/`lo`.
- State machine: IDLE -> RUN on `start` with a mul/div code while in IDLE; RUN counts WIDTH iterations, then -> DONE; DONE -> IDLE after one cycle. Operands are latched when `start` is accepted.
- Multiply: shift-add on operand magnitudes, sign fixed up at the end. {hi,lo} receives the 2·WIDTH-bit product.
- Divide: restoring division on magnitudes. lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Divide by zero: hi = dividend, lo = all ones. `done` still pulses normally.
- DIV of most-negative by -1: lo = most-negative, hi = 0.
- `start` while not in IDLE, or with a non-mul/div code, is ignored.

## Timing
- Combinational ops: zero-cycle latency; `zero` and `overflow` follow `aluResult` combinationally.
- `start` accepted at edge E: `busy` = 1 from E through E+WIDTH. At edge E+WIDTH+1, `busy` = 0, `done` = 1, and `hi`/`lo` update. `done` clears at the next edge.
- MFHI/MFLO during `busy` return the old HI/LO.
- `start` in the cycle `done` is high is ignored; earliest accept is the following cycle.
- Reset value of all registered outputs: `hi` = `lo` = 0, `busy` = `done` = 0, state IDLE.
- Reset mid-operation aborts the operation and clears HI/LO. No `done` is produced.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIV/DIVU supported as above.
- `ALU_SEQ_DIV_EN` undefined: the divider is not built. DIV/DIVU codes behave as unknown codes: `aluResult` = 0, `start` ignored, HI/LO unchanged. MULT/MULTU are unaffected.

## Structure
- Package `alu_seq_pkg`: `aluControl` code constants and the IDLE/RUN/DONE state enum.
- Sub-module `mul_div_unit`: holds the FSM, iteration counter, operand/accumulator registers and HI/LO. The top level keeps the combinational ops and the output mux.

## Test plan
- WIDTH=32; ADD 0x7FFFFFFF + 1 -> `aluResult` 0x80000000, `overflow` 1, `zero` 0. SUB 5-5 -> `zero` 1.
- SRA 0x80000000, `shamt` 4 -> 0xF8000000. SLT -7 vs 3 -> 1. NOR 0, 0 -> 0xFFFFFFFF.
- MULT -3 × 7 with `start` -> `done` exactly 33 cycles after the accept edge, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULTU 0xFFFFFFFF × 2 -> hi = 1, lo = 0xFFFFFFFE.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 10 / 0 -> hi = 10, lo = 0xFFFFFFFF.
- Second `start` while busy is ignored. Reset asserted mid-RUN -> `busy` 0 next cycle, hi = lo = 0, no `done`.
- MFLO during `busy` returns the previous lo; after `done`, returns the new value.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: operation codes and FSM state constants.
// ALU_SEQ_DIV_EN enables the iterative divider (DIV/DIVU).
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Codes that may launch the iterative unit in this build
    function automatic logic is_md_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// EX-stage ALU bus: operands, op select, start/busy/done and HI/LO.
// master drives operands and start; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic [WIDTH-1:0]   input1;
    logic [WIDTH-1:0]   input2;
    logic [3:0]         aluControl;
    logic [SHAMT_W-1:0] shamt;
    logic               start;
    logic [WIDTH-1:0]   aluResult;
    logic               zero;
    logic               overflow;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output input1, input2, aluControl, shamt, start,
        input  aluResult, zero, overflow, busy, done, hi, lo
    );

    modport slave (
        input  input1, input2, aluControl, shamt, start,
        output aluResult, zero, overflow, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_seq_mul_div_unit.sv
// Iterative multiply/divide with HI/LO: shift-add multiply, restoring
// divide on magnitudes (divide built only with ALU_SEQ_DIV_EN).
module mul_div_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   dvs;
    logic               neg_lo;
    logic               sgn;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    logic               accept;

`ifdef ALU_SEQ_DIV_EN
    logic               is_div;
    logic               neg_hi;
    logic               dz;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
`endif

    assign accept = (state == ST_IDLE) && start && is_md_op(op);
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    always_comb begin
        sgn = (op == OP_MULT);
`ifdef ALU_SEQ_DIV_EN
        sgn = sgn | (op == OP_DIV);
`endif
        sa    = sgn & a[WIDTH-1];
        sb    = sgn & b[WIDTH-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // Multiplier sits in acc_lo and is consumed LSB first
    always_comb begin
        mul_sum = {1'b0, acc_hi}
                + (acc_lo[0] ? {1'b0, dvs} : '0);
        nxt_hi  = mul_sum[WIDTH:1];
        nxt_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        prod    = {acc_hi, acc_lo};
        if (neg_lo) begin
            prod = -prod;
        end
        fin_hi  = prod[2*WIDTH-1:WIDTH];
        fin_lo  = prod[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        // A zero divisor leaves the dividend in acc_hi, quotient all ones
        div_sh  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, dvs};
        div_rem = div_ge ? WIDTH'(div_sh - {1'b0, dvs})
                         : div_sh[WIDTH-1:0];
        if (is_div) begin
            nxt_hi = div_rem;
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
            fin_hi = neg_hi ? -acc_hi : acc_hi;
            fin_lo = (neg_lo && !dz) ? -acc_lo : acc_lo;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dvs    <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= mag_b;
                        dvs    <= mag_a;
                        neg_lo <= sa ^ sb;
`ifdef ALU_SEQ_DIV_EN
                        is_div <= is_div_op(op);
                        neg_hi <= sa;
                        dz     <= (b == '0);
                        if (is_div_op(op)) begin
                            acc_lo <= mag_a;
                            dvs    <= mag_b;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (cnt == LAST) begin
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        state <= ST_DONE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU: single-cycle ops plus iterative mul/div with HI/LO.
// Divider present only when ALU_SEQ_DIV_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic     clk,
    input logic     reset,
    alu_seq_if.slave bus
);
    if (WIDTH < 8 || WIDTH % 2 != 0 || SHAMT_W != $clog2(WIDTH))
    begin : g_bad_cfg
        $error("alu_seq: WIDTH/SHAMT_W out of range");
    end

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    assign a    = bus.input1;
    assign b    = bus.input2;
    assign sum  = a + b;
    assign diff = a - b;

    mul_div_unit #(
        .WIDTH(WIDTH)
    ) u_md (
        .clk   (clk),
        .reset (reset),
        .op    (bus.aluControl),
        .a     (a),
        .b     (b),
        .start (bus.start),
        .busy  (bus.busy),
        .done  (bus.done),
        .hi    (hi_q),
        .lo    (lo_q)
    );

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (bus.aluControl)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_NOR: res = ~(a | b);
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1])
                   && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1])
                   && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}},
                           ($signed(a) < $signed(b))};
            OP_SLL: res = b << bus.shamt;
            OP_SRL: res = b >> bus.shamt;
            OP_SRA: res = $unsigned($signed(b) >>> bus.shamt);
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase
    end

    assign bus.aluResult = res;
    assign bus.zero      = (res == '0);
    assign bus.overflow  = ovf;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
